multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer replacing the single-cycle control unit of the CPU.
- Steps one instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the existing datapath mux selects and write strobes.
- Shares one memory port between instruction fetch and data access through a req/ready handshake.

Parameters:
RETIRE_W, 32, width of retired-instruction counter instret (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  clock, rising edge
pcrst  in  1  asynchronous active-low reset
op  in  6  opcode from instruction register, inst[31:26]
func  in  6  function field, inst[5:0]
z  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
iord  out  1  memory address select: 0=PC, 1=ALU result
ir_we  out  1  instruction register load
mdr_we  out  1  memory data register load
pc_we  out  1  PC load
Pcsrc  out  2  00=PC+4, 10=branch target, 11=jump target
Regrt  out  1  1=write rt, 0=write rd
Se  out  1  1=sign-extend, 0=zero-extend immediate
Aluqb  out  1  1=ALU B from register qb, 0=from immediate
Aluc  out  2  00=add, 01=sub, 10=and, 11=or
Wreg  out  1  register file write strobe
Wmem  out  1  data memory write strobe
Reg2reg  out  1  1=write-back ALU result, 0=memory data
state  out  3  current state, debug
instret  out  RETIRE_W  retired instruction count
trap  out  1  illegal-instruction trap (tied 0 without feature)

Behaviour:
- Reset (pcrst=0, async): state=FETCH, instret=0, trap=0; all strobes 0 (mem_req, ir_we, mdr_we, pc_we, Wreg, Wmem); selects 0. Any in-flight memory access is abandoned; on release, FETCH restarts from the current PC.
- ISA:
  - R-type op 000000 with func add 100000, sub 100010, and 100100, or 100101.
  - addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- Decode: Regrt, Se, Aluqb, Aluc, Reg2reg are combinational from op/func.
  - The IR is stable from DECODE to instruction end.
  - Se=1 for addi/lw/sw/beq/bne; 0 otherwise.
  - Aluc=sub for sub/beq/bne.
- Strobes come from the state register; each is a single-cycle pulse.
- FETCH:
  - mem_req=1, iord=0; hold while mem_ready=0.
  - When mem_ready=1: ir_we=1 -> DECODE.
- DECODE: one cycle, no strobes -> EXEC.
- EXEC:
  - R-type/addi/andi/ori -> WB.
  - lw/sw -> MEM.
  - beq/bne: pc_we=1, Pcsrc=10 if taken (beq: z=1; bne: z=0), else 00 -> FETCH.
  - j: pc_we=1, Pcsrc=11 -> FETCH.
- MEM:
  - mem_req=1, iord=1; hold while mem_ready=0.
  - lw: on ready, mdr_we=1 -> WB.
  - sw: Wmem=1 only in the ready cycle (exactly one write), pc_we=1, Pcsrc=00 -> FETCH.
- WB: Wreg=1, pc_we=1, Pcsrc=00 -> FETCH; Reg2reg=0 for lw, 1 otherwise.
- PC is written only once per instruction, at its final cycle, so branch target = PC+4+(sext(imm)<<2) matches single-cycle semantics.
- instret increments in every pc_we cycle; wraps to 0 after all-ones.
- Latency with mem_ready tied high (cycles):
  - R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3.
  - Each wait cycle on mem_ready adds one.
- Illegal opcode/func (feature off): treated as NOP; EXEC asserts pc_we, Pcsrc=00 -> FETCH, counted in instret.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; undefined codes recover to FETCH.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal instruction in EXEC -> TRAP. TRAP sets trap=1, asserts no strobes and no pc_we, does not increment instret, and is held until reset.
- Undefined: TRAP state is absent, trap tied 0, NOP behaviour as above.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode and func constants
  - Aluc codes (ALU_ADD/SUB/AND/OR)
  - Pcsrc codes (PC_SEQ/PC_BR/PC_JMP)
  - state encodings
  - an is_legal function
- One sub-module, ctrl_decode: combinational op/func -> Regrt, Se, Aluqb, Aluc, Reg2reg, instruction class (alu, load, store, branch, jump, illegal).
- The FSM and instret counter stay in multicycle_ctrl.

Test Plan:
- add (op 0, func 100000), mem_ready=1 -> states 0,1,2,4; WB cycle: Wreg=1, Regrt=0, Reg2reg=1, pc_we=1, Pcsrc=00; instret 0->1.
- lw (100011), mem_ready low for 3 cycles in MEM -> mem_req, iord=1 held 4 cycles; mdr_we once; WB: Reg2reg=0, Regrt=1, Se=1; total 8 cycles.
- sw (101011), mem_ready low 2 cycles -> Wmem asserted exactly once, in the ready cycle; pc_we in the same cycle; Wreg never asserted.
- beq with z=1, then bne with z=1 -> first: EXEC pc_we=1, Pcsrc=10; second: Pcsrc=00; each 3 cycles; Aluc=01.
- pcrst driven low mid-MEM of lw -> all strobes 0 asynchronously, instret=0, state=0; after release, FETCH with mem_req=1, iord=0.
- op 111111 -> feature off: pc_we=1, Pcsrc=00, instret+1. Feature on: state=5, trap=1, no strobes for 10+ cycles until reset.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, function codes,
// ALU and PC select codes, FSM state encodings and instruction classes.
package cpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } aluc_e;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b10,
      PC_JMP = 2'b11
   } pcsrc_e;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ILLEGAL
   } iclass_e;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] func);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE: ok = (func == FN_ADD) || (func == FN_SUB) ||
                        (func == FN_AND) || (func == FN_OR);
         OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
         OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: datapath selects and instruction class
// derived purely from the opcode and function fields of the IR.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] func_i,
   output logic       regrt_o,
   output logic       se_o,
   output logic       aluqb_o,
   output logic [1:0] aluc_o,
   output logic       reg2reg_o,
   output iclass_e    iclass_o
);

   always_comb begin
      regrt_o   = 1'b0;
      se_o      = 1'b0;
      aluqb_o   = 1'b0;
      aluc_o    = ALU_ADD;
      reg2reg_o = 1'b1;
      iclass_o  = CLS_ILLEGAL;
      if (is_legal(op_i, func_i)) begin
         case (op_i)
            OP_RTYPE: begin
               iclass_o = CLS_ALU;
               aluqb_o  = 1'b1;
               case (func_i)
                  FN_SUB:  aluc_o = ALU_SUB;
                  FN_AND:  aluc_o = ALU_AND;
                  FN_OR:   aluc_o = ALU_OR;
                  default: aluc_o = ALU_ADD;
               endcase
            end
            OP_ADDI: begin
               iclass_o = CLS_ALU;
               regrt_o  = 1'b1;
               se_o     = 1'b1;
            end
            OP_ANDI: begin
               iclass_o = CLS_ALU;
               regrt_o  = 1'b1;
               aluc_o   = ALU_AND;
            end
            OP_ORI: begin
               iclass_o = CLS_ALU;
               regrt_o  = 1'b1;
               aluc_o   = ALU_OR;
            end
            OP_LW: begin
               iclass_o  = CLS_LOAD;
               regrt_o   = 1'b1;
               se_o      = 1'b1;
               reg2reg_o = 1'b0;
            end
            OP_SW: begin
               iclass_o = CLS_STORE;
               regrt_o  = 1'b1;
               se_o     = 1'b1;
            end
            // Branches compare two registers, hence qb and a subtract.
            OP_BEQ, OP_BNE: begin
               iclass_o = CLS_BRANCH;
               se_o     = 1'b1;
               aluqb_o  = 1'b1;
               aluc_o   = ALU_SUB;
            end
            OP_J: iclass_o = CLS_JUMP;
            default: iclass_o = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Define ILLEGAL_TRAP_EN to park illegal instructions in TRAP until reset (else they retire as NOPs).
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                pcrst,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   input  logic                z,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                iord,
   output logic                ir_we,
   output logic                mdr_we,
   output logic                pc_we,
   output logic [1:0]          Pcsrc,
   output logic                Regrt,
   output logic                Se,
   output logic                Aluqb,
   output logic [1:0]          Aluc,
   output logic                Wreg,
   output logic                Wmem,
   output logic                Reg2reg,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] instret,
   output logic                trap
);

   state_e              state_q, state_d;
   logic [RETIRE_W-1:0] instret_q, instret_d;
   iclass_e             iclass;
   logic                br_taken;

   ctrl_decode u_decode (
      .op_i      (op),
      .func_i    (func),
      .regrt_o   (Regrt),
      .se_o      (Se),
      .aluqb_o   (Aluqb),
      .aluc_o    (Aluc),
      .reg2reg_o (Reg2reg),
      .iclass_o  (iclass)
   );

   assign br_taken = (op == OP_BEQ) ? z : ~z;

   always_ff @(posedge clk or negedge pcrst) begin
      if (!pcrst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      iord    = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      pc_we   = 1'b0;
      Pcsrc   = PC_SEQ;
      Wreg    = 1'b0;
      Wmem    = 1'b0;
      // Strobes stay low for the whole reset window, not only at the edge.
      if (pcrst) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
               case (iclass)
                  CLS_ALU:             state_d = S_WB;
                  CLS_LOAD, CLS_STORE: state_d = S_MEM;
                  CLS_BRANCH: begin
                     pc_we   = 1'b1;
                     Pcsrc   = br_taken ? PC_BR : PC_SEQ;
                     state_d = S_FETCH;
                  end
                  CLS_JUMP: begin
                     pc_we   = 1'b1;
                     Pcsrc   = PC_JMP;
                     state_d = S_FETCH;
                  end
                  default: begin
`ifdef ILLEGAL_TRAP_EN
                     state_d = S_TRAP;
`else
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
`endif
                  end
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               if (mem_ready) begin
                  if (iclass == CLS_LOAD) begin
                     mdr_we  = 1'b1;
                     state_d = S_WB;
                  end else begin
                     // Store finishes in its ready cycle: one write, PC advances together.
                     Wmem    = 1'b1;
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
                  end
               end
            end
            S_WB: begin
               Wreg    = 1'b1;
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign instret_d = pc_we ? instret_q + 1'b1 : instret_q;

   assign state   = state_q;
   assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
   assign trap = (state_q == S_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random instruction
// stream checked against a per-instruction latency/strobe model (also covers ILLEGAL_TRAP_EN).
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          pcrst;
   logic [5:0]    op, func;
   logic          z, mem_ready;
   logic          mem_req, iord, ir_we, mdr_we, pc_we;
   logic [1:0]    Pcsrc, Aluc;
   logic          Regrt, Se, Aluqb, Wreg, Wmem, Reg2reg;
   logic [2:0]    state;
   logic [RW-1:0] instret;
   logic          trap;

   int total = 0;
   int bad   = 0;
   int exp_ir = 0;

   // observations of the last instruction run
   int         obs_cycles, obs_irwe, obs_mdrwe, obs_wmem, obs_wreg, obs_pcwe;
   int         obs_memd, obs_memf, obs_wmem_bad;
   logic [1:0] obs_pcsrc, obs_aluc;
   logic       obs_regrt, obs_se, obs_aluqb, obs_reg2reg;
   string      obs_trace;
   bit         obs_timeout;

   int         base_lat [6] = '{4, 5, 4, 3, 3, 3};
   logic [5:0] tbl_op [12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                               6'b001000, 6'b001100, 6'b001101, 6'b100011,
                               6'b101011, 6'b000100, 6'b000101, 6'b000010};
   logic [5:0] tbl_fn [4]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};

   always #5 clk = ~clk;

   multicycle_ctrl #(.RETIRE_W(RW)) dut (
      .clk(clk), .pcrst(pcrst), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we),
      .Pcsrc(Pcsrc), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc), .Wreg(Wreg),
      .Wmem(Wmem), .Reg2reg(Reg2reg), .state(state), .instret(instret), .trap(trap)
   );

   // ---------------- reference model ----------------
   // class: 0 alu, 1 load, 2 store, 3 branch, 4 jump, 5 illegal
   function automatic int cls_of(logic [5:0] o, logic [5:0] f);
      case (o)
         6'b000000: return (f == 6'b100000 || f == 6'b100010 ||
                            f == 6'b100100 || f == 6'b100101) ? 0 : 5;
         6'b001000, 6'b001100, 6'b001101: return 0;
         6'b100011: return 1;
         6'b101011: return 2;
         6'b000100, 6'b000101: return 3;
         6'b000010: return 4;
         default:   return 5;
      endcase
   endfunction

   function automatic string exp_trace(int cls, int fw, int mw);
      string s;
      s = "";
      for (int i = 0; i <= fw; i++) s = {s, "0"};
      s = {s, "12"};
      if (cls == 1 || cls == 2) for (int i = 0; i <= mw; i++) s = {s, "3"};
      if (cls == 0 || cls == 1) s = {s, "4"};
      return s;
   endfunction

   function automatic logic [1:0] exp_aluc(logic [5:0] o, logic [5:0] f);
      if (o == 6'b000000) begin
         if (f == 6'b100010) return 2'd1;
         if (f == 6'b100100) return 2'd2;
         if (f == 6'b100101) return 2'd3;
         return 2'd0;
      end
      if (o == 6'b001100) return 2'd2;
      if (o == 6'b001101) return 2'd3;
      if (o == 6'b000100 || o == 6'b000101) return 2'd1;
      return 2'd0;
   endfunction

   // ---------------- stimulus driver ----------------
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zz,
                            input int fw, input int mw);
      int  fcnt, mcnt;
      bit  done;
      op = o; func = f; z = zz;
      fcnt = 0; mcnt = 0; done = 0;
      obs_cycles = 0; obs_irwe = 0; obs_mdrwe = 0; obs_wmem = 0; obs_wreg = 0;
      obs_pcwe = 0; obs_memd = 0; obs_memf = 0; obs_wmem_bad = 0;
      obs_trace = ""; obs_timeout = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         #1;
         if (mem_req && !iord) begin
            mem_ready = (fcnt == fw);
            fcnt++;
         end else if (mem_req && iord) begin
            mem_ready = (mcnt == mw);
            mcnt++;
         end
         #1;
         obs_cycles++;
         obs_trace = {obs_trace, $sformatf("%0d", state)};
         obs_irwe  += int'(ir_we);
         obs_mdrwe += int'(mdr_we);
         obs_wmem  += int'(Wmem);
         obs_wreg  += int'(Wreg);
         obs_pcwe  += int'(pc_we);
         obs_memd  += int'(mem_req && iord);
         obs_memf  += int'(mem_req && !iord);
         if (Wmem && !(mem_ready && pc_we)) obs_wmem_bad++;
         if (pc_we) begin
            obs_pcsrc = Pcsrc; obs_aluc = Aluc; obs_regrt = Regrt;
            obs_se = Se; obs_aluqb = Aluqb; obs_reg2reg = Reg2reg;
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      mem_ready = 1'b0;
      if (!done) obs_timeout = 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      pcrst = 1'b0; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;
      #12;
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if ({mem_req, ir_we, mdr_we, pc_we, Wreg, Wmem} !== 6'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 000000", {mem_req, ir_we, mdr_we, pc_we, Wreg, Wmem}); end
      total++; if ({iord, Pcsrc} !== 3'b0) begin bad++; $display("FAIL reset_selects: got %b want 000", {iord, Pcsrc}); end
      total++; if (instret !== '0) begin bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
      total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap: got %b want 0", trap); end
      @(negedge clk); pcrst = 1'b1; #1;
      total++; if ({state, mem_req, iord} !== {3'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL reset_release: got state=%0d mem_req=%b iord=%b want 0 1 0", state, mem_req, iord); end
      exp_ir = 0;
      $display("reset: state=%0d instret=%0d", state, instret);
   endtask

   task automatic test_add();
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if (obs_timeout) begin bad++; $display("FAIL add_timeout: got no pc_we want pc_we"); end
      total++; if (obs_trace != "0124") begin bad++; $display("FAIL add_trace: got %s want 0124", obs_trace); end
      total++; if ({obs_wreg, obs_pcwe} !== {32'd1, 32'd1}) begin bad++; $display("FAIL add_strobes: got wreg=%0d pc_we=%0d want 1 1", obs_wreg, obs_pcwe); end
      total++; if ({obs_regrt, obs_reg2reg, obs_pcsrc} !== 4'b0100) begin
         bad++; $display("FAIL add_selects: got regrt=%b reg2reg=%b pcsrc=%b want 0 1 00", obs_regrt, obs_reg2reg, obs_pcsrc); end
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL add_instret: got %0d want %0d", instret, exp_ir); end
      $display("add: trace=%s instret=%0d", obs_trace, instret);
   endtask

   task automatic test_lw_wait();
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if (obs_trace != "01233334") begin bad++; $display("FAIL lw_trace: got %s want 01233334", obs_trace); end
      total++; if (obs_cycles != 8) begin bad++; $display("FAIL lw_cycles: got %0d want 8", obs_cycles); end
      total++; if ({obs_memd, obs_mdrwe} !== {32'd4, 32'd1}) begin bad++; $display("FAIL lw_mem: got memd=%0d mdr_we=%0d want 4 1", obs_memd, obs_mdrwe); end
      total++; if ({obs_reg2reg, obs_regrt, obs_se} !== 3'b011) begin
         bad++; $display("FAIL lw_selects: got reg2reg=%b regrt=%b se=%b want 0 1 1", obs_reg2reg, obs_regrt, obs_se); end
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_ir); end
      $display("lw: trace=%s cycles=%0d", obs_trace, obs_cycles);
   endtask

   task automatic test_sw_wait();
      run_instr(6'b101011, 6'b000000, 1'b0, 0, 2);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if (obs_trace != "012333") begin bad++; $display("FAIL sw_trace: got %s want 012333", obs_trace); end
      total++; if ({obs_wmem, obs_wmem_bad, obs_wreg, obs_pcwe} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
         bad++; $display("FAIL sw_strobes: got wmem=%0d misplaced=%0d wreg=%0d pc_we=%0d want 1 0 0 1", obs_wmem, obs_wmem_bad, obs_wreg, obs_pcwe); end
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL sw_instret: got %0d want %0d", instret, exp_ir); end
      $display("sw: trace=%s wmem=%0d", obs_trace, obs_wmem);
   endtask

   task automatic test_branch();
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if ({obs_cycles, obs_pcsrc, obs_aluc} !== {32'd3, 2'b10, 2'b01}) begin
         bad++; $display("FAIL beq_taken: got cycles=%0d pcsrc=%b aluc=%b want 3 10 01", obs_cycles, obs_pcsrc, obs_aluc); end
      $display("beq z=1: pcsrc=%b cycles=%0d", obs_pcsrc, obs_cycles);
      run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if ({obs_cycles, obs_pcsrc, obs_aluc} !== {32'd3, 2'b00, 2'b01}) begin
         bad++; $display("FAIL bne_not_taken: got cycles=%0d pcsrc=%b aluc=%b want 3 00 01", obs_cycles, obs_pcsrc, obs_aluc); end
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL branch_instret: got %0d want %0d", instret, exp_ir); end
      $display("bne z=1: pcsrc=%b cycles=%0d", obs_pcsrc, obs_cycles);
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      bit got;
      op = 6'b111111; func = 6'b000000; z = 1'b0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk); mem_ready = 1'b0; #1;
         if (mem_req && !iord) mem_ready = 1'b1;
         #1;
         if (state == 3'd5) got = 1;
      end
      mem_ready = 1'b0;
      total++; if (!got) begin bad++; $display("FAIL trap_entry: got state=%0d want 5", state); end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
         total++;
         if ({trap, state, mem_req, ir_we, mdr_we, pc_we, Wreg, Wmem} !== {1'b1, 3'd5, 6'b0}) begin
            bad++; $display("FAIL trap_hold: got trap=%b state=%0d strobes=%b want 1 5 000000", trap, state,
                            {mem_req, ir_we, mdr_we, pc_we, Wreg, Wmem});
         end
      end
      mem_ready = 1'b0;
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL trap_instret: got %0d want %0d", instret, exp_ir); end
      pcrst = 1'b0; #2;
      total++; if ({trap, state} !== 4'b0) begin bad++; $display("FAIL trap_reset: got trap=%b state=%0d want 0 0", trap, state); end
      @(negedge clk); pcrst = 1'b1; #1;
      exp_ir = 0;
      $display("illegal(trap): held in state 5, cleared by reset");
`else
      run_instr(6'b111111, 6'b000000, 1'b0, 1, 0);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if (obs_trace != "0012") begin bad++; $display("FAIL nop_trace: got %s want 0012", obs_trace); end
      total++; if ({obs_pcwe, obs_pcsrc, obs_wreg, obs_wmem, trap} !== {32'd1, 2'b00, 32'd0, 32'd0, 1'b0}) begin
         bad++; $display("FAIL nop_strobes: got pc_we=%0d pcsrc=%b wreg=%0d wmem=%0d trap=%b want 1 00 0 0 0",
                         obs_pcwe, obs_pcsrc, obs_wreg, obs_wmem, trap); end
      total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL nop_instret: got %0d want %0d", instret, exp_ir); end
      $display("illegal(nop): trace=%s instret=%0d", obs_trace, instret);
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         int         idx, fw, mw, cls;
         logic [5:0] o, f;
         logic       zz, rtype;
         string      got_s, want_s;
         logic [5:0] got_d, want_d, mask;
         idx = int'($urandom_range(0, 11));
         o   = tbl_op[idx];
         f   = (idx < 4) ? tbl_fn[idx] : 6'($urandom_range(0, 63));
         zz  = 1'($urandom_range(0, 1));
         fw  = int'($urandom_range(0, 2));
         mw  = int'($urandom_range(0, 2));
         cls = cls_of(o, f);
         run_instr(o, f, zz, fw, mw);
         exp_ir = (exp_ir + 1) % (1 << RW);
         got_s = $sformatf("to=%0d cyc=%0d ir=%0d mdr=%0d wm=%0d wmbad=%0d wr=%0d pc=%0d memd=%0d memf=%0d pcsrc=%0d",
                           obs_timeout, obs_cycles, obs_irwe, obs_mdrwe, obs_wmem, obs_wmem_bad, obs_wreg,
                           obs_pcwe, obs_memd, obs_memf, obs_pcsrc);
         want_s = $sformatf("to=0 cyc=%0d ir=1 mdr=%0d wm=%0d wmbad=0 wr=%0d pc=1 memd=%0d memf=%0d pcsrc=%0d",
                            base_lat[cls] + fw + ((cls == 1 || cls == 2) ? mw : 0),
                            (cls == 1), (cls == 2), (cls == 0 || cls == 1),
                            (cls == 1 || cls == 2) ? mw + 1 : 0, fw + 1,
                            (cls == 4) ? 3 : ((cls == 3 && (o == 6'b000100 ? zz : !zz)) ? 2 : 0));
         total++; if (got_s != want_s) begin bad++; $display("FAIL rnd_strobes[%0d]: got %s want %s", n, got_s, want_s); end
         total++; if (obs_trace != exp_trace(cls, fw, mw)) begin
            bad++; $display("FAIL rnd_trace[%0d]: got %s want %s", n, obs_trace, exp_trace(cls, fw, mw)); end
         rtype  = (o == 6'b000000);
         got_d  = {obs_regrt, obs_se, obs_aluqb, obs_aluc, obs_reg2reg};
         want_d = {!rtype,
                   (o == 6'b001000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b000101),
                   rtype, exp_aluc(o, f), (o != 6'b100011)};
         mask   = {(cls <= 1), 1'b1, (cls <= 2), 2'b11, (cls <= 1)};
         total++; if ((got_d & mask) !== (want_d & mask)) begin
            bad++; $display("FAIL rnd_decode[%0d]: got %b want %b (mask %b)", n, got_d, want_d, mask); end
         total++; if (instret !== RW'(exp_ir)) begin bad++; $display("FAIL rnd_instret[%0d]: got %0d want %0d", n, instret, exp_ir); end
         $display("rnd %0d: op=%b func=%b z=%b fw=%0d mw=%0d trace=%s instret=%0d", n, o, f, zz, fw, mw, obs_trace, instret);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      op = 6'b100011; func = 6'b000000; z = 1'b0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk); mem_ready = 1'b0; #1;
         if (mem_req && !iord) mem_ready = 1'b1;
         #1;
         if (state == 3'd3) got = 1;
      end
      mem_ready = 1'b0;
      total++; if (!got) begin bad++; $display("FAIL mid_reach_mem: got state=%0d want 3", state); end
      #1 pcrst = 1'b0;
      #1;
      exp_ir = 0;
      total++; if ({state, mem_req, iord, ir_we, mdr_we, pc_we, Wreg, Wmem} !== {3'd0, 7'b0}) begin
         bad++; $display("FAIL mid_reset_async: got state=%0d strobes=%b want 0 0000000", state,
                         {mem_req, iord, ir_we, mdr_we, pc_we, Wreg, Wmem}); end
      total++; if (instret !== '0) begin bad++; $display("FAIL mid_reset_instret: got %0d want 0", instret); end
      @(negedge clk); pcrst = 1'b1; #1;
      total++; if ({state, mem_req, iord} !== {3'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL mid_release: got state=%0d mem_req=%b iord=%b want 0 1 0", state, mem_req, iord); end
      run_instr(6'b000000, 6'b100101, 1'b0, 0, 0);
      exp_ir = (exp_ir + 1) % (1 << RW);
      total++; if (obs_trace != "0124" || instret !== RW'(exp_ir)) begin
         bad++; $display("FAIL mid_restart: got trace=%s instret=%0d want 0124 %0d", obs_trace, instret, exp_ir); end
      $display("reset mid-MEM: restart trace=%s instret=%0d", obs_trace, instret);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_sw_wait();
      test_branch();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
